// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control FSM.
// Contents: state encodings (the 4-bit estado codes), the supported opcode
// constants, alu_op codes, branch funct3 codes and the one-hot opcode class
// produced by ctrl_opcode_decoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'b0000,
    S_DECODE = 4'b0001,
    S_EXEC   = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB     = 4'b0100,
    S_PCUPD  = 4'b1000
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic rtype;
    logic itype;
    logic load;
    logic store;
    logic branch;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// Combinational opcode classifier.
// Ports:
//   opcode - instruction[6:0]
//   cls    - one-hot class {rtype, itype, load, store, branch, illegal}
module ctrl_opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:      cls.rtype   = 1'b1;
      OP_I:      cls.itype   = 1'b1;
      OP_LOAD:   cls.load    = 1'b1;
      OP_STORE:  cls.store   = 1'b1;
      OP_BRANCH: cls.branch  = 1'b1;
      default:   cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control FSM sequencing the multicycle RV32I datapath:
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> PCUPD -> FETCH.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   opcode, funct3       - IR fields, latched in DECODE
//   zero                 - ALU zero flag, used in EXEC for branch resolution
//   mem_ready            - memory access complete (FETCH and MEM)
//   estado               - current state code (PC block advances on 4'b1000)
//   pcsrc                - branch taken, valid during PCUPD
//   ir_write, mem_read, mem_write, reg_write, alu_src, mem_to_reg, alu_op
//                        - datapath controls
//   illegal              - one-cycle pulse in DECODE on an unknown opcode
//   mem_timeout          - sticky memory-wait timeout flag
// Optional build macro CTRL_PERF_CNT_EN adds instret and cycle_cnt counters.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  estado,
  output logic        pcsrc,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic        mem_timeout
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] cycle_cnt
`endif
);

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (MEM_WAIT_MAX > 0) ? CW'(MEM_WAIT_MAX - 1) : '0;

  state_t          state_q, state_d;
  logic [6:0]      opc_q;
  logic [2:0]      f3_q;
  logic            pcsrc_q;
  logic            skip_q;
  logic            tmo_q;
  logic [CW-1:0]   cnt_q;

  logic [6:0]      dec_op;
  op_class_t       cls;
  logic            wait_st;
  logic            tmo_hit;
  logic            taken;

  // In DECODE the opcode has not been latched yet, so classify the live IR
  // field; everywhere else use the latched copy.
  assign dec_op = (state_q == S_DECODE) ? opcode : opc_q;

  ctrl_opcode_decoder u_dec (
    .opcode (dec_op),
    .cls    (cls)
  );

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM);
  // Fires on the last permitted waiting cycle so the FSM leaves on the edge
  // that would otherwise bring the counter to MEM_WAIT_MAX.
  assign tmo_hit = (MEM_WAIT_MAX != 0) && wait_st && !mem_ready && (cnt_q == WAIT_LAST);
  assign taken   = ((f3_q == F3_BEQ) && zero) || ((f3_q == F3_BNE) && !zero);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (tmo_hit) state_d = S_PCUPD;
        else              state_d = S_FETCH;
      end
      S_DECODE: state_d = cls.illegal ? S_PCUPD : S_EXEC;
      S_EXEC: begin
        if (cls.rtype || cls.itype)     state_d = S_WB;
        else if (cls.load || cls.store) state_d = S_MEM;
        else                            state_d = S_PCUPD;
      end
      S_MEM: begin
        if (mem_ready)    state_d = cls.load ? S_WB : S_PCUPD;
        else if (tmo_hit) state_d = S_PCUPD;
        else              state_d = S_MEM;
      end
      S_WB:    state_d = S_PCUPD;
      S_PCUPD: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Latched instruction fields, branch decision, wait counter, error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q   <= '0;
      f3_q    <= '0;
      pcsrc_q <= 1'b0;
      skip_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (state_q == S_DECODE) begin
        opc_q <= opcode;
        f3_q  <= funct3;
      end
      // EXEC is a single cycle and a branch always goes straight to PCUPD,
      // so pcsrc is high only during that PCUPD and clears on its exit.
      pcsrc_q <= (state_q == S_EXEC) && cls.branch && taken;
      skip_q  <= (state_d == S_PCUPD) &&
                 (tmo_hit || ((state_q == S_DECODE) && cls.illegal));
      if (tmo_hit) tmo_q <= 1'b1;
      cnt_q   <= (wait_st && !mem_ready && !tmo_hit) ? cnt_q + 1'b1 : '0;
    end
  end

  // Outputs. Strobes are gated by rst_n so nothing is asserted while reset
  // is held even though estado sits at FETCH.
  always_comb begin
    estado      = state_q;
    pcsrc       = pcsrc_q;
    mem_timeout = tmo_q;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_op      = ALU_ADD;
    illegal     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        S_DECODE: illegal = cls.illegal;
        S_EXEC: begin
          alu_src = cls.itype || cls.load || cls.store;
          if (cls.rtype || cls.itype) alu_op = ALU_FUNCT;
          else if (cls.branch)        alu_op = ALU_SUB;
          else                        alu_op = ALU_ADD;
        end
        S_MEM: begin
          mem_read  = cls.load;
          mem_write = cls.store;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = cls.load;
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret   <= '0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((state_q == S_PCUPD) && !skip_q) instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. Each scenario task queues
// per-cycle stimulus together with the expected output vector, then drains
// the queue one clock at a time, comparing at the falling edge.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic [3:0]  estado;
  logic        pcsrc, ir_write, mem_read, mem_write, reg_write;
  logic        alu_src, mem_to_reg, illegal, mem_timeout;
  logic [1:0]  alu_op;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret, cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .estado(estado), .pcsrc(pcsrc), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .illegal(illegal), .mem_timeout(mem_timeout)
`ifdef CTRL_PERF_CNT_EN
    , .instret(instret), .cycle_cnt(cycle_cnt)
`endif
  );

  // {estado, pcsrc, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
  //  alu_src, alu_op, illegal, mem_timeout}
  logic [14:0] obs;
  assign obs = {estado, pcsrc, ir_write, mem_read, mem_write, reg_write,
                mem_to_reg, alu_src, alu_op, illegal, mem_timeout};

  typedef struct {
    logic        rdy;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic [14:0] v;
  } exp_t;

  exp_t sb[$];
  logic [6:0] op_c;
  logic [2:0] f3_c;
  logic       z_c;
  logic       t;   // expected mem_timeout for pushed entries

  function automatic logic [14:0] mk(input logic [3:0] st, input logic pcs, irw, mr, mw,
                                     rw, m2r, as, input logic [1:0] aop, input logic ill);
    return {st, pcs, irw, mr, mw, rw, m2r, as, aop, ill, t};
  endfunction

  task automatic push(input logic rdy, input logic [14:0] v);
    sb.push_back('{rdy: rdy, op: op_c, f3: f3_c, z: z_c, v: v});
  endtask

  // Sequence builders for standard states (expected values written out)
  task automatic p_fetch(input logic rdy); push(rdy, mk(4'h0, 0, rdy, 1, 0, 0, 0, 0, 2'b00, 0)); endtask
  task automatic p_decode();               push(1'b1, mk(4'h1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0)); endtask
  task automatic p_pcupd(input logic pcs); push(1'b1, mk(4'h8, pcs, 0, 0, 0, 0, 0, 0, 2'b00, 0)); endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", obs, 15'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    exp_t e;
    int n = 0;
    op_c = 7'b0110011; f3_c = 3'b000; z_c = 1'b0; t = 1'b0;
    p_fetch(1);
    p_decode();
    push(1, mk(4'h2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0));
    push(1, mk(4'h4, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
    p_pcupd(0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; opcode = e.op; funct3 = e.f3; zero = e.z;
      @(negedge clk); n++; checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL rtype cycle %0d got %b want %b", n, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    int n = 0;
    op_c = 7'b0000011; f3_c = 3'b010; z_c = 1'b0; t = 1'b0;
    p_fetch(1);
    p_decode();
    push(1, mk(4'h2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    for (int i = 0; i < 3; i++) push(0, mk(4'h3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
    push(1, mk(4'h3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
    push(1, mk(4'h4, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0));
    p_pcupd(0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; opcode = e.op; funct3 = e.f3; zero = e.z;
      @(negedge clk); n++; checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL load_wait cycle %0d got %b want %b", n, obs, e.v);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL load_wait_len got %0d want 9", n);
    end
  endtask

  task automatic test_branch();
    exp_t e;
    int n = 0;
    // {funct3, zero, taken}
    logic [4:0] cases [4] = '{{3'b000, 1'b1, 1'b1}, {3'b001, 1'b1, 1'b0},
                              {3'b001, 1'b0, 1'b1}, {3'b100, 1'b1, 1'b0}};
    t = 1'b0;
    op_c = 7'b1100011;
    for (int k = 0; k < 4; k++) begin
      f3_c = cases[k][4:2]; z_c = cases[k][1];
      p_fetch(1);
      p_decode();
      push(1, mk(4'h2, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0));
      p_pcupd(cases[k][0]);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; opcode = e.op; funct3 = e.f3; zero = e.z;
      @(negedge clk); n++; checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL branch cycle %0d got %b want %b", n, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    int n = 0;
    op_c = 7'b1111111; f3_c = 3'b000; z_c = 1'b1; t = 1'b0;
    p_fetch(1);
    push(1, mk(4'h1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    p_pcupd(0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; opcode = e.op; funct3 = e.f3; zero = e.z;
      @(negedge clk); n++; checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL illegal cycle %0d got %b want %b", n, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n = 0;
    t = 1'b0; z_c = 1'b0;
    op_c = 7'b0010011; f3_c = 3'b000;   // I-type ALU
    p_fetch(1); p_decode();
    push(1, mk(4'h2, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0));
    push(1, mk(4'h4, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
    p_pcupd(0);
    op_c = 7'b0100011; f3_c = 3'b010;   // store
    p_fetch(1); p_decode();
    push(1, mk(4'h2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    push(1, mk(4'h3, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    p_pcupd(0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; opcode = e.op; funct3 = e.f3; zero = e.z;
      @(negedge clk); n++; checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %b want %b", n, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int n = 0;
    z_c = 1'b0; t = 1'b0;
    // 14 waiting cycles is one short of the limit: instruction completes
    op_c = 7'b0110011; f3_c = 3'b000;
    for (int i = 0; i < 14; i++) p_fetch(0);
    p_fetch(1); p_decode();
    push(1, mk(4'h2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0));
    push(1, mk(4'h4, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
    p_pcupd(0);
    // 15 waiting cycles: timeout, instruction skipped
    for (int i = 0; i < 15; i++) p_fetch(0);
    t = 1'b1;
    p_pcupd(0);
    // store that will be reset while waiting in MEM
    op_c = 7'b0100011; f3_c = 3'b010;
    p_fetch(1); p_decode();
    push(1, mk(4'h2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    push(0, mk(4'h3, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; opcode = e.op; funct3 = e.f3; zero = e.z;
      @(negedge clk); n++; checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL timeout cycle %0d got %b want %b", n, obs, e.v);
      end
      @(posedge clk); #1;
    end
    // still in MEM with mem_write up; reset asynchronously mid-cycle
    checks++;
    if (mem_write !== 1'b1 || estado !== 4'h3) begin
      errors++;
      $display("FAIL pre_reset_mem got estado %h mem_write %b want 3 1", estado, mem_write);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (estado !== 4'h0 || mem_write !== 1'b0 || mem_read !== 1'b0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got estado %h mw %b mr %b tmo %b want 0 0 0 0",
               estado, mem_write, mem_read, mem_timeout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_mem_timeout();
    exp_t e;
    int n = 0;
    z_c = 1'b0; t = 1'b0;
    op_c = 7'b0100011; f3_c = 3'b010;
    p_fetch(1); p_decode();
    push(1, mk(4'h2, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    for (int i = 0; i < 15; i++) push(0, mk(4'h3, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
    t = 1'b1;
    p_pcupd(0);
    p_fetch(1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; opcode = e.op; funct3 = e.f3; zero = e.z;
      @(negedge clk); n++; checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL mem_timeout cycle %0d got %b want %b", n, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic test_perf();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1; zero = 1'b1; funct3 = 3'b000;
    opcode = 7'b0110011; repeat (5) @(posedge clk); #1;
    opcode = 7'b0100011; repeat (5) @(posedge clk); #1;
    opcode = 7'b1100011; repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (instret !== 32'd3 || cycle_cnt !== 32'd14) begin
      errors++;
      $display("FAIL perf got instret %0d cycle_cnt %0d want 3 14", instret, cycle_cnt);
    end
  endtask
`endif

  // Read and write strobes must never overlap
  always @(negedge clk) begin
    checks++;
    if (mem_read && mem_write) begin
      errors++;
      $display("FAIL rw_exclusive got mr %b mw %b want not both", mem_read, mem_write);
    end
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_mem_timeout();
`ifdef CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
